riscv_core_issue_ctrl: RTL
==========================

# riscv_core_issue_ctrl

Issue controller between `riscv_core_id` (decode) and the execute stage. It owns a 32-entry register scoreboard and stalls decoded instructions on RAW/WAW hazards. It serialises control flow by holding issue while a branch or jump is unresolved. It drains the pipeline and raises a trap request on illegal instructions. The instruction payload register is external and is loaded by `issue_en`; this block holds only the handshake, the scoreboard and the destination tag.

## Interface
- `MAX_INFLIGHT`, 4, maximum issued-but-not-written-back instructions with a nonzero rd; legal range 1..15.
- `clk  in  1  clock; all state updates on the rising edge`
- `rstn  in  1  asynchronous active-low reset`
- `id_valid  in  1  decode holds an instruction`
- `id_ready  out  1  instruction consumed this cycle; combinational`
- `id_rsj_addr, id_rsk_addr, id_rsd_addr  in  5 each  register indices`
- `id_rsj_valid, id_rsk_valid, id_rsd_valid  in  1 each  operand/destination used`
- `id_is_branch  in  1  branch_funct nonzero (branch, JAL, JALR)`
- `id_illegal  in  1  illegal_instr from decode`
- `issue_en  out  1  id_valid & id_ready & !id_illegal; load enable for payload register`
- `ex_valid  out  1  execute-stage payload valid`
- `ex_ready  in  1  execute accepts payload`
- `ex_rsd_addr  out  5  registered destination tag`
- `ex_rsd_valid  out  1  registered destination valid (0 when rd = x0)`
- `wb_valid  in  1  writeback this cycle`
- `wb_rd_addr  in  5  writeback destination`
- `br_resolve_valid  in  1  outstanding branch/jump resolved`
- `trap_req  out  1  illegal-instruction trap request`
- `trap_ack  in  1  trap accepted`
- `sb_busy  out  32  scoreboard; bit 0 is always 0`
- `inflight  out  4  count of busy scoreboard bits`

## Operation
- Writeback: when `wb_valid` is high, `wb_rd_addr` != 0 and that bit is busy, the bit clears and `inflight` decrements. Writebacks to x0 or to a non-busy register are ignored.
- Effective busy (`eb`) = `sb_busy` with the same-cycle writeback bit already cleared. This is a writeback bypass.
- hazard = (rsj_valid & eb[rsj]) | (rsk_valid & eb[rsk]) | (rsd_valid & rsd != 0 & eb[rsd]).
- slot_free = !ex_valid | ex_ready.
- cap_ok = !(rsd_valid & rsd != 0) | (inflight_after_wb < MAX_INFLIGHT).
- FSM states:
  - RUN:
    - Legal instruction: `id_ready` = id_valid & !hazard & slot_free & cap_ok. On issue with a nonzero rd, set sb_busy[rd] and increment `inflight`. A same-cycle set and clear of one bit leaves it busy, and the counter is unchanged. An issued `id_is_branch` instruction moves the FSM to BR_WAIT.
    - Illegal instruction (id_valid & id_illegal): `id_ready` = 0 and the FSM moves to TRAP_DRAIN.
  - BR_WAIT: `id_ready` = 0. On `br_resolve_valid` the FSM returns to RUN, and issue resumes the following cycle. Any flush of fetch/decode is the front end's job; this block holds no wrong-path state.
  - TRAP_DRAIN: `id_ready` = 0. The FSM moves to TRAP when `inflight` = 0 and `ex_valid` = 0.
  - TRAP: `trap_req` = 1. On `trap_ack`, `id_ready` = 1 for that cycle to consume the illegal instruction, `issue_en` = 0, and the FSM returns to RUN.
- `br_resolve_valid` outside BR_WAIT and `trap_ack` outside TRAP are ignored.
- Execute register: on issue, `ex_valid` = 1, `ex_rsd_addr` = rsd, and `ex_rsd_valid` = rsd_valid & rsd != 0. If there is no issue and `ex_ready` is high, `ex_valid` = 0.

## Timing
- Reset (async, `rstn` low): FSM = RUN, `sb_busy` = 0, `inflight` = 0, `ex_valid` = 0, `ex_rsd_addr` = 0, `ex_rsd_valid` = 0, `trap_req` = 0. Reset mid-operation drops all in-flight state immediately.
- `id_ready`, `issue_en` and `trap_req` are combinational from state and inputs. There is no combinational path from `id_*` to `ex_*`.
- Issue-to-`ex_valid` latency is 1 cycle. Throughput is 1 instruction/cycle with no hazards and `ex_ready` held high.
- A writeback in cycle N unblocks a dependent issue in cycle N.
- A branch issued in cycle N blocks cycles N+1 up to and including the resolve cycle.
- `inflight` saturates by construction: issue is blocked at `MAX_INFLIGHT`, and a decrement at 0 cannot occur.

## Test plan
- **Back-to-back issue:** issue `add x1,x2,x3` then `add x4,x5,x6` with `ex_ready` = 1 -> both issue in consecutive cycles; `sb_busy` = 0x12; `inflight` = 2.
- **RAW stall and bypass:** x1 busy, issue an instruction with rsj = x1 -> `id_ready` = 0 until the `wb_valid` / `wb_rd_addr` = 1 cycle, when `id_ready` = 1 in that same cycle.
- **x0 destination:** issue with rsd = 0 and rsd_valid = 1 -> no scoreboard bit set, `inflight` unchanged, `ex_rsd_valid` = 0.
- **Inflight cap:** MAX_INFLIGHT = 4, four writers outstanding, fifth present -> `id_ready` = 0; one writeback -> fifth issues that cycle with `inflight` held at 4.
- **Branch wait:** branch issued at cycle 10, `br_resolve_valid` at cycle 14 -> `id_ready` = 0 for cycles 11–14, next issue at cycle 15.
- **Illegal instruction:** illegal with 2 writers outstanding -> `trap_req` rises the cycle after the last writeback drains `ex_valid`; `trap_ack` -> `id_ready` = 1 and `issue_en` = 0 that cycle, then RUN. Assert `rstn` low mid-TRAP_DRAIN -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/riscv_core_issue_ctrl.sv
// Issue controller: register scoreboard with writeback bypass, branch serialisation
// and illegal-instruction drain/trap handshake between decode and execute.
module riscv_core_issue_ctrl #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_rsj_addr,
  input  logic [4:0]  id_rsk_addr,
  input  logic [4:0]  id_rsd_addr,
  input  logic        id_rsj_valid,
  input  logic        id_rsk_valid,
  input  logic        id_rsd_valid,
  input  logic        id_is_branch,
  input  logic        id_illegal,
  output logic        issue_en,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [4:0]  ex_rsd_addr,
  output logic        ex_rsd_valid,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd_addr,
  input  logic        br_resolve_valid,
  output logic        trap_req,
  input  logic        trap_ack,
  output logic [31:0] sb_busy,
  output logic [3:0]  inflight
);

  localparam logic [3:0] MAX_INF = 4'(MAX_INFLIGHT);

  typedef enum logic [1:0] {RUN, BR_WAIT, TRAP_DRAIN, TRAP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_sb;
  logic [3:0]  r_inflight;
  logic        r_ex_valid;
  logic [4:0]  r_ex_rsd_addr;
  logic        r_ex_rsd_valid;

  logic        w_wb_clr, w_rd_nz, w_hazard, w_slot_free, w_cap_ok, w_issue, w_set;
  logic [31:0] w_clr_mask, w_set_mask, w_eb;
  logic [3:0]  w_inf_wb;

  // Writeback bypass: a register written back this cycle already counts as free.
  assign w_wb_clr    = wb_valid & (wb_rd_addr != 5'd0) & r_sb[wb_rd_addr];
  assign w_clr_mask  = w_wb_clr ? (32'd1 << wb_rd_addr) : 32'd0;
  assign w_eb        = r_sb & ~w_clr_mask;
  assign w_inf_wb    = r_inflight - {3'd0, w_wb_clr};

  assign w_rd_nz     = id_rsd_valid & (id_rsd_addr != 5'd0);
  assign w_hazard    = (id_rsj_valid & w_eb[id_rsj_addr]) |
                       (id_rsk_valid & w_eb[id_rsk_addr]) |
                       (w_rd_nz & w_eb[id_rsd_addr]);
  assign w_slot_free = !r_ex_valid | ex_ready;
  assign w_cap_ok    = !w_rd_nz | (w_inf_wb < MAX_INF);

  always_comb begin
    w_state_nxt = r_state;
    id_ready    = 1'b0;
    w_issue     = 1'b0;
    trap_req    = 1'b0;
    case (r_state)
      RUN: begin
        if (id_valid & id_illegal) begin
          w_state_nxt = TRAP_DRAIN;
        end else begin
          id_ready = id_valid & !w_hazard & w_slot_free & w_cap_ok;
          w_issue  = id_ready;
          if (w_issue & id_is_branch) w_state_nxt = BR_WAIT;
        end
      end
      BR_WAIT: if (br_resolve_valid) w_state_nxt = RUN;
      TRAP_DRAIN: if ((w_inf_wb == 4'd0) && !r_ex_valid) w_state_nxt = TRAP;
      TRAP: begin
        trap_req = 1'b1;
        // The ack consumes the illegal instruction without issuing it.
        if (trap_ack) begin
          id_ready    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_set      = w_issue & w_rd_nz;
  assign w_set_mask = w_set ? (32'd1 << id_rsd_addr) : 32'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= RUN;
      r_sb           <= 32'd0;
      r_inflight     <= 4'd0;
      r_ex_valid     <= 1'b0;
      r_ex_rsd_addr  <= 5'd0;
      r_ex_rsd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Set wins over a same-cycle clear of the same bit; the counter nets to zero.
      r_sb       <= (w_eb | w_set_mask) & ~32'd1;
      r_inflight <= r_inflight + {3'd0, w_set} - {3'd0, w_wb_clr};
      if (w_issue) begin
        r_ex_valid     <= 1'b1;
        r_ex_rsd_addr  <= id_rsd_addr;
        r_ex_rsd_valid <= w_rd_nz;
      end else if (ex_ready) begin
        r_ex_valid     <= 1'b0;
      end
    end
  end

  assign issue_en     = w_issue;
  assign ex_valid     = r_ex_valid;
  assign ex_rsd_addr  = r_ex_rsd_addr;
  assign ex_rsd_valid = r_ex_rsd_valid;
  assign sb_busy      = r_sb;
  assign inflight     = r_inflight;

endmodule
